// File: rtl/kexpand_seq.sv
// rtl/kexpand_seq.sv - iterative AES-128/192/256 key-schedule engine, one word per clock,
// full schedule held internally and served as 128-bit round keys.
module kexpand_seq #(
  parameter int MAX_NK = 8,
  parameter int RD_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         keys_valid,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  output logic         rd_valid
);

  localparam int NW_MAX = 4 * (MAX_NK + 7);
  localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_GEN  = 1'b1;

  // FIPS-197 S-box, entry 0x00 in the top byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [0:0]  state_q, state_d;
  logic [5:0]  i_q, i_d;
  logic [2:0]  mod_q, mod_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [3:0]  nk_q, nk_d, nr_q, nr_d;
  logic        kv_q, kv_d, done_q, done_d, err_q, err_d;
  logic [31:0] mem_q [NW_MAX];

  logic [3:0]  nk_sel, nr_sel;
  logic        len_ok, accept;
  logic [31:0] w_prev, w_back, temp, w_new;

  always_comb begin
    nk_sel = 4'd4;
    nr_sel = 4'd10;
    len_ok = 1'b1;
    case (key_len)
      2'd0: ;
      2'd1: begin nk_sel = 4'd6; nr_sel = 4'd12; end
      2'd2: begin nk_sel = 4'd8; nr_sel = 4'd14; end
      default: len_ok = 1'b0;
    endcase
    if (nk_sel > MAX_NK_W) len_ok = 1'b0;
  end

  assign accept = (state_q == S_IDLE) && start && len_ok;

  always_comb begin
    w_prev = mem_q[i_q - 6'd1];
    w_back = mem_q[i_q - {2'b00, nk_q}];
    if (mod_q == 3'd0)
      temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && mod_q == 3'd4)
      temp = sub_word(w_prev);
    else
      temp = w_prev;
    w_new = w_back ^ temp;
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    mod_d   = mod_q;
    rcon_d  = rcon_q;
    nk_d    = nk_q;
    nr_d    = nr_q;
    kv_d    = kv_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          nk_d    = nk_sel;
          nr_d    = nr_sel;
          kv_d    = 1'b0;
          i_d     = {2'b00, nk_sel};
          mod_d   = 3'd0;
          rcon_d  = 8'h01;
          state_d = S_GEN;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      default: begin
        i_d   = i_q + 6'd1;
        mod_d = ({1'b0, mod_q} == nk_q - 4'd1) ? 3'd0 : mod_q + 3'd1;
        if (mod_q == 3'd0)
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        // Last word index is Nw-1 = 4*Nr+3
        if (i_q == {nr_q, 2'b11}) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          kv_d    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      mod_q   <= '0;
      rcon_q  <= '0;
      nk_q    <= '0;
      nr_q    <= '0;
      kv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      mod_q   <= mod_d;
      rcon_q  <= rcon_d;
      nk_q    <= nk_d;
      nr_q    <= nr_d;
      kv_q    <= kv_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Schedule storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < MAX_NK; j++)
        if (4'(j) < nk_sel) mem_q[6'(j)] <= key_in[255 - 32*j -: 32];
    end else if (state_q == S_GEN) begin
      mem_q[i_q] <= w_new;
    end
  end

  logic         rd_hit;
  logic [5:0]   rd_base;
  logic [127:0] rd_word;

  always_comb begin
    rd_base = {rd_round, 2'b00};
    rd_hit  = kv_q && (rd_round <= nr_q);
    rd_word = '0;
    if (rd_hit)
      rd_word = {mem_q[rd_base], mem_q[rd_base + 6'd1],
                 mem_q[rd_base + 6'd2], mem_q[rd_base + 6'd3]};
  end

  generate
    if (RD_REG != 0) begin : g_rd_reg
      logic [127:0] rd_key_q;
      logic         rd_valid_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_key_q   <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_key_q   <= rd_word;
          rd_valid_q <= rd_hit;
        end
      end
      assign rd_key   = rd_key_q;
      assign rd_valid = rd_valid_q;
    end else begin : g_rd_comb
      assign rd_key   = rd_word;
      assign rd_valid = rd_hit;
    end
  endgenerate

  assign busy       = (state_q == S_GEN);
  assign done       = done_q;
  assign err        = err_q;
  assign keys_valid = kv_q;

endmodule

// File: tb/tb_kexpand_seq.sv
// tb/tb_kexpand_seq.sv - scoreboard bench for kexpand_seq using FIPS-197 key-expansion vectors.
module tb_kexpand_seq;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                   128'hdeadbeefcafef00d0123456789abcdef};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                   64'hffffffff00000000};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic [255:0] key_in = '0;
  logic         busy, done, err, keys_valid, rd_valid;
  logic [3:0]   rd_round = 4'd0;
  logic [127:0] rd_key;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    string        nm;
    logic         v;
    logic [127:0] k;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      done_q[$];

  kexpand_seq #(.MAX_NK(8), .RD_REG(1)) dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .done(done), .err(err), .keys_valid(keys_valid),
    .rd_round(rd_round), .rd_key(rd_key), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Monitor: done pulses against the expected completion cycle
  always @(negedge clk) begin : done_mon
    int e;
    if (done) begin
      if (done_q.size() == 0) begin
        chk1("done_unexpected", done, 1'b0);
      end else begin
        e = done_q.pop_front();
        chk("done_cycle", 128'(cyc), 128'(e));
      end
    end
  end

  // Monitor: a read issued before an edge is checked just after it
  initial begin : rd_mon
    rd_exp_t e;
    forever begin
      @(posedge clk);
      if (rd_q.size() > 0) begin
        e = rd_q.pop_front();
        #1;
        chk1({e.nm, "_valid"}, rd_valid, e.v);
        chk({e.nm, "_key"}, rd_key, e.k);
      end
    end
  end

  task automatic rd(input logic [3:0] r, input logic v, input logic [127:0] k, input string nm);
    rd_exp_t e;
    rd_round = r;
    e.nm = nm;
    e.v  = v;
    e.k  = k;
    rd_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic start_job(input logic [1:0] kl, input logic [255:0] k, input int span,
                           output int e0);
    key_len = kl;
    key_in  = k;
    start   = 1'b1;
    e0 = cyc + 1;
    if (span > 0) done_q.push_back(e0 + span);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_kv(input string nm);
    int n;
    n = 0;
    while (!keys_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1(nm, keys_valid, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin : stim
    int e0;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_kv", keys_valid, 1'b0);
    chk1("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_key", rd_key, '0);
    @(negedge clk);
    rst = 1'b0;

    // AES-128
    start_job(2'd0, K128, 40, e0);
    chk1("a128_busy", busy, 1'b1);
    chk1("a128_kv_low", keys_valid, 1'b0);
    rd(4'd0, 1'b0, '0, "a128_rd_during_gen");
    wait_kv("a128_kv");
    rd(4'd0, 1'b1, R128_0, "a128_r0");
    rd(4'd1, 1'b1, R128_1, "a128_r1");
    rd(4'd10, 1'b1, R128_10, "a128_r10");
    rd(4'd11, 1'b0, '0, "a128_r11");

    // Reserved key length is rejected
    start_job(2'd3, K256, 0, e0);
    chk1("rej_err", err, 1'b1);
    chk1("rej_busy", busy, 1'b0);
    chk1("rej_kv", keys_valid, 1'b1);
    @(negedge clk);
    chk1("rej_err_pulse", err, 1'b0);
    rd(4'd10, 1'b1, R128_10, "rej_r10");

    // AES-192
    start_job(2'd1, K192, 46, e0);
    wait_kv("a192_kv");
    rd(4'd0, 1'b1, R192_0, "a192_r0");
    rd(4'd12, 1'b1, R192_12, "a192_r12");
    rd(4'd13, 1'b0, '0, "a192_r13");

    // AES-256
    start_job(2'd2, K256, 52, e0);
    wait_kv("a256_kv");
    rd(4'd0, 1'b1, R256_0, "a256_r0");
    rd(4'd14, 1'b1, R256_14, "a256_r14");
    rd(4'd15, 1'b0, '0, "a256_r15");

    // start at E0+10 of a running job is ignored
    start_job(2'd0, K128, 40, e0);
    repeat (9) @(negedge clk);
    key_len = 2'd2;
    key_in  = K256;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk1("ign_err", err, 1'b0);
    chk1("ign_busy", busy, 1'b1);
    wait_kv("ign_kv");
    rd(4'd10, 1'b1, R128_10, "ign_r10");

    // Reset mid-expansion
    start_job(2'd0, K128, 0, e0);
    repeat (19) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_kv", keys_valid, 1'b0);
    chk1("mid_rst_rd_valid", rd_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rd(4'd0, 1'b0, '0, "mid_rst_rd");
    start_job(2'd0, K128, 40, e0);
    wait_kv("restart_kv");
    rd(4'd10, 1'b1, R128_10, "restart_r10");

    // Asynchronous reset while a valid read is being presented
    rd_round = 4'd10;
    @(posedge clk);
    #2;
    chk1("idle_rd_valid_pre", rd_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk1("idle_rst_kv", keys_valid, 1'b0);
    chk1("idle_rst_rd_valid", rd_valid, 1'b0);
    chk("idle_rst_rd_key", rd_key, '0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back: start held across the done cycle
    key_len = 2'd1;
    key_in  = K192;
    start   = 1'b1;
    e0 = cyc + 1;
    done_q.push_back(e0 + 46);
    done_q.push_back(e0 + 47 + 40);
    @(negedge clk);
    key_len = 2'd0;
    key_in  = K128;
    chk1("b2b_busy1", busy, 1'b1);
    repeat (46) @(negedge clk);
    chk1("b2b_done1", done, 1'b1);
    chk1("b2b_kv1", keys_valid, 1'b1);
    chk1("b2b_idle", busy, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk1("b2b_kv_drop", keys_valid, 1'b0);
    chk1("b2b_busy2", busy, 1'b1);
    wait_kv("b2b_kv2");
    rd(4'd0, 1'b1, R128_0, "b2b_r0");
    rd(4'd10, 1'b1, R128_10, "b2b_r10");

    repeat (2) @(negedge clk);
    chk("done_queue_drained", 128'(done_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
